// File: rtl/pool_stream_ctrl.sv
// 2x2 max-pool over a raster pixel stream: one result per 2x2 block, 1-cycle latency from the accepting edge.
// Backpressure: in_ready drops while a result is waiting and out_ready is low, so no result is ever overwritten.
module pool_stream_ctrl #(
  parameter int DATA_W = 4,
  parameter int IMG_W  = 16,
  parameter int IMG_H  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic              pix_done;
  logic [DATA_W-1:0] pair_q;
  logic [DATA_W-1:0] pm;
  logic [DATA_W-1:0] lb_rd;
  logic [DATA_W-1:0] res;
  logic [DATA_W-1:0] line_buf [IMG_W/2];
  logic              accept;
  logic              out_hs;
  logic              frame_start;
  logic              col_last;
  logic              row_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    busy        = 1'b0;
    done        = 1'b0;
    frame_start = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt   = RUN;
          frame_start = 1'b1;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (out_hs && out_last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // pix_done keeps the input closed between the last pixel and the final handshake
  assign in_ready = (state == RUN) && !pix_done && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign out_hs   = out_valid && out_ready;
  assign col_last = (col == CW'(IMG_W - 1));
  assign row_last = (row == RW'(IMG_H - 1));

  assign pm    = (in_data > pair_q) ? in_data : pair_q;
  assign lb_rd = line_buf[col[CW-1:1]];
  assign res   = (lb_rd > pm) ? lb_rd : pm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col      <= '0;
      row      <= '0;
      pix_done <= 1'b0;
    end else if (frame_start) begin
      col      <= '0;
      row      <= '0;
      pix_done <= 1'b0;
    end else if (accept) begin
      if (col_last) begin
        col <= '0;
        if (row_last) pix_done <= 1'b1;
        else          row      <= row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   pair_q <= '0;
    else if (frame_start)         pair_q <= '0;
    else if (accept && !col[0])   pair_q <= in_data;
  end

  // every entry is written on an even row before the odd row reads it
  always_ff @(posedge clk) begin
    if (accept && !row[0] && col[0]) line_buf[col[CW-1:1]] <= pm;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (frame_start) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (accept && row[0] && col[0]) begin
      out_valid <= 1'b1;
      out_data  <= res;
      out_last  <= row_last && col_last;
    end else if (out_hs) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pool_stream_ctrl.sv
// Bench for pool_stream_ctrl: directed frames with randomized handshakes, checked against a block-max model.
module tb_pool_stream_ctrl;

  localparam int DW = 4;
  localparam int W  = 16;
  localparam int H  = 16;
  localparam int NR = (W / 2) * (H / 2);
  localparam int NP = W * H;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          out_ready;
  logic          busy;
  logic          done;

  int n_checks = 0;
  int n_err    = 0;

  logic [DW-1:0] pix [H][W];
  logic [DW-1:0] exp_res [NR];
  logic [DW-1:0] got [NR];

  pool_stream_ctrl #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: each result is the max of its 2x2 block, listed in output raster order.
  task automatic build_model();
    for (int r = 0; r < H / 2; r++)
      for (int c = 0; c < W / 2; c++) begin
        logic [DW-1:0] m;
        m = pix[2*r][2*c];
        if (pix[2*r][2*c+1]   > m) m = pix[2*r][2*c+1];
        if (pix[2*r+1][2*c]   > m) m = pix[2*r+1][2*c];
        if (pix[2*r+1][2*c+1] > m) m = pix[2*r+1][2*c+1];
        exp_res[r*(W/2)+c] = m;
      end
  endtask

  task automatic fill_random();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) pix[r][c] = DW'($urandom_range(0, (1 << DW) - 1));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  in_ready,  0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"},  out_data,  0);
    check({tag, "_out_last"},  out_last,  0);
    check({tag, "_busy"},      busy,      0);
    check({tag, "_done"},      done,      0);
  endtask

  // Runs one frame; rand_v/rand_r randomize in_valid/out_ready, stall5 holds out_ready low
  // for five cycles on result 0, restart_at pulses start at that pixel, abort_at resets there.
  task automatic run_frame(input bit rand_v, input bit rand_r, input bit stall5,
                           input int restart_at, input int abort_at);
    int idx = 0;
    int rcnt = 0;
    int cyc = 0;
    int stall_n = 0;
    bit restarted = 1'b0;
    bit aborted = 1'b0;
    build_model();
    @(negedge clk);
    start = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1 check("busy_in_run", busy, 1);
    while (rcnt < NR && cyc < 4000) begin
      if (abort_at >= 0 && idx == abort_at) begin
        rst_n = 1'b0; in_valid = 1'b0;
        #1 check_reset_outputs("abort");
        aborted = 1'b1;
        break;
      end
      start = 1'b0;
      if (restart_at >= 0 && idx == restart_at && !restarted) begin
        start = 1'b1;
        restarted = 1'b1;
      end
      in_valid  = rand_v ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_data   = (idx < NP) ? pix[idx / W][idx % W] : '0;
      out_ready = rand_r ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (stall5 && out_valid && rcnt == 0 && stall_n < 5) begin
        out_ready = 1'b0;
        stall_n++;
      end
      #1;
      if (out_valid) begin
        check($sformatf("data_r%0d", rcnt), out_data, exp_res[rcnt]);
        check($sformatf("last_r%0d", rcnt), out_last, rcnt == NR - 1);
      end
      if (out_valid && !out_ready) check("in_ready_stall", in_ready, 0);
      if (in_valid && in_ready) idx++;
      if (out_valid && out_ready) begin
        got[rcnt] = out_data;
        rcnt++;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    in_valid = 1'b0;
    if (aborted) begin
      check("abort_pixel_count", idx, abort_at);
    end else begin
      check("result_count", rcnt, NR);
      check("pixel_count", idx, NP);
      check("stall_cycles", stall_n, stall5 ? 5 : 0);
      #1;
      check("done_pulse", done, 1);
      check("busy_in_done", busy, 0);
      @(negedge clk);
      #1;
      check("done_cleared", done, 0);
      check("busy_after", busy, 0);
      check("in_ready_idle", in_ready, 0);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1 check_reset_outputs("reset");
    rst_n = 1'b1;

    // pixels offered while idle must be ignored
    in_valid = 1'b1; in_data = 4'hF; out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1 check("idle_in_ready", in_ready, 0);
      check("idle_out_valid", out_valid, 0);
    end
    in_valid = 1'b0;

    // all-zero frame, free-running handshakes
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) pix[r][c] = '0;
    run_frame(1'b0, 1'b0, 1'b0, -1, -1);

    // horizontal ramp: every output row reads 1,3,...,15
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) pix[r][c] = DW'(c % 16);
    run_frame(1'b1, 1'b1, 1'b0, -1, -1);
    for (int k = 0; k < NR; k++) check($sformatf("ramp_r%0d", k), got[k], 2 * (k % 8) + 1);

    // two isolated hot pixels in the first and last blocks
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) pix[r][c] = '0;
    pix[1][1] = 4'd15;
    pix[15][14] = 4'd9;
    run_frame(1'b1, 1'b1, 1'b0, -1, -1);
    check("hot_first", got[0], 15);
    check("hot_last", got[NR-1], 9);
    check("hot_mid", got[27], 0);

    // downstream stall on the first result
    fill_random();
    run_frame(1'b1, 1'b0, 1'b1, -1, -1);

    // start pulsed mid-frame is ignored
    fill_random();
    run_frame(1'b1, 1'b1, 1'b0, 40, -1);

    // reset mid-frame aborts, then a clean frame follows
    fill_random();
    run_frame(1'b1, 1'b1, 1'b0, -1, 100);
    repeat (2) @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      #1 check("post_abort_quiet", out_valid, 0);
    end
    fill_random();
    run_frame(1'b1, 1'b1, 1'b0, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/pool_stream_ctrl.md
POOL_STREAM_CTRL -- requirements
Module: pool_stream_ctrl

Interface
REQ-001 The module SHALL have parameter DATA_W, default 4, meaning unsigned pixel width.
REQ-002 The module SHALL have parameter IMG_W, default 16, meaning input columns (even, power of 2).
REQ-003 The module SHALL have parameter IMG_H, default 16, meaning input rows (even).
REQ-004 Port clk  input  1  is the single clock; all logic SHALL be rising-edge.
REQ-005 Port rst_n  input  1  is the reset, asynchronous and active-low.
REQ-006 Port start  input  1  is a frame start pulse.
REQ-007 Port in_valid  input  1  is the pixel valid.
REQ-008 Port in_data  input  DATA_W  is the pixel, raster order, row-major.
REQ-009 Port in_ready  output  1  is the pixel accept.
REQ-010 Port out_valid  output  1  is the pooled result valid.
REQ-011 Port out_data  output  DATA_W  is the 2x2 max result.
REQ-012 Port out_last  output  1  is high with the final (IMG_W/2*IMG_H/2-th) result.
REQ-013 Port out_ready  input  1  is the downstream accept.
REQ-014 Port busy  output  1  is high in RUN.
REQ-015 Port done  output  1  is a one-cycle pulse at frame completion.

Function
REQ-016 The FSM SHALL have exactly three states, IDLE, RUN and DONE: IDLE->RUN on start; RUN->DONE on the output handshake with out_last=1; DONE->IDLE unconditionally after 1 cycle.
REQ-017 start SHALL be ignored in RUN and DONE.
REQ-018 On IDLE->RUN, the column counter, row counter, pair register and output register SHALL all clear.
REQ-019 A pixel is accepted when in_valid && in_ready.
REQ-020 in_ready SHALL be high only in RUN && (!out_valid || out_ready), which is a combinational term on out_ready.
REQ-021 The column counter SHALL increment per accepted pixel and wrap at IMG_W-1 to 0, incrementing the row counter.
REQ-022 The row counter SHALL saturate at the end of the frame; no pixels are accepted after the last one.
REQ-023 On an even column, the pixel SHALL be stored in the pair register.
REQ-024 On an odd column, pm SHALL equal max(pair register, pixel), using an unsigned compare; ties yield that value.
REQ-025 On an even row with an odd column, pm SHALL be written to line buffer entry col>>1 (IMG_W/2 entries of DATA_W).
REQ-026 On an odd row with an odd column, out_data SHALL be registered as max(line buffer entry [col>>1], pm) and out_valid set on the same clock edge; out_valid is therefore high in the cycle after the accepting edge.
REQ-027 out_valid SHALL hold, with out_data and out_last stable, until out_ready; it clears on a handshake unless a new result is loaded on the same edge.
REQ-028 A result SHALL never be overwritten or dropped while out_valid && !out_ready.
REQ-029 out_last SHALL be asserted for the result produced by the final pixel of the frame (row IMG_H-1, col IMG_W-1).
REQ-030 done SHALL pulse in DONE; busy=1 only in RUN.
REQ-031 in_valid outside RUN SHALL have no effect.
REQ-032 Result order SHALL be raster order of the output map, IMG_W/2*IMG_H/2 results per frame.

Reset
REQ-033 rst_n=0 SHALL asynchronously force IDLE and set in_ready=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0, counters=0 and pair register=0.
REQ-034 Line buffer contents need not be reset (every entry is rewritten before it is read).
REQ-035 Reset mid-frame SHALL abort the frame with no further output; the next start SHALL begin a clean frame.

Verification
REQ-036 The bench SHALL cover: all-zero frame, out_ready=1 -> 64 results of 0, out_last on the 64th, done one cycle after the 64th handshake, busy low after.
REQ-037 The bench SHALL cover: pixel=(col mod 16) -> every output row reads 1,3,5,...,15.
REQ-038 The bench SHALL cover: pixel(1,1)=15, pixel(14,15)=9, all others 0 -> result 0=15, result 63=9, all others 0.
REQ-039 The bench SHALL cover: out_ready low 5 cycles at result 0 -> in_ready low during the stall, out_data held, 64 correct results in order, no loss.
REQ-040 The bench SHALL cover: start pulsed again at pixel 40 -> ignored, frame completes normally; rst_n low after 100 pixels -> all outputs 0 immediately; new start -> full 64-result frame.
